// File: rtl/register_file_shadowed.sv
// General-register file for the PA-RISC datapath.
// NREGS x WIDTH storage with R0 hardwired to zero. Two combinational read
// ports see a same-cycle write through a bypass. One synchronous write port.
// Selected registers (SHADOW_MASK) carry a shadow copy. The shadow copy is
// saved on interruption (SaveShadow) and restored on RFI (RestShadow).
module register_file_shadowed #(
  parameter int               WIDTH       = 32,
  parameter int               NREGS       = 32,
  parameter logic [NREGS-1:0] SHADOW_MASK = 32'h0303_0302,
  localparam int              AW          = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             LE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    RA_A,
  input  logic [AW-1:0]    RA_B,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  input  logic             SaveShadow,
  input  logic             RestShadow,
  output logic             ShadowValid
);

  // Snapshot tracking: IDLE until a save, VALID until the next restore.
  typedef enum logic {
    SNAP_IDLE  = 1'b0,
    SNAP_VALID = 1'b1
  } snap_state_e;

  snap_state_e snap_state_q;
  snap_state_e snap_state_d;

  // Flat view of every GR. The read muxes index this view. Entry 0 is the constant zero.
  logic [WIDTH-1:0] gr_view [NREGS];

  assign gr_view[0] = '0;

  // Read-port value: R0 reads zero, then a pending write bypasses storage.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    ra,
    input logic [WIDTH-1:0] stored,
    input logic             le,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd
  );
    logic [WIDTH-1:0] q;
    q = stored;
    if (le && (wa == ra)) q = wd;
    if (ra == '0)         q = '0;
    return q;
  endfunction

  // Snapshot state register.
  // NOTE: state registers use non-blocking assignments. All flops then
  // sample pre-edge values, so a save and a restore on the same edge swap cleanly.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) snap_state_q <= SNAP_IDLE;
    else     snap_state_q <= snap_state_d;
  end

  // Next snapshot state. A save wins over a restore, so save plus restore stays VALID.
  // NOTE: default assigned first so every path drives the output and no latch is inferred.
  always_comb begin
    snap_state_d = snap_state_q;
    if (SaveShadow)      snap_state_d = SNAP_VALID;
    else if (RestShadow) snap_state_d = SNAP_IDLE;
  end

  assign ShadowValid = (snap_state_q == SNAP_VALID);

  // One block per architected register, R1..R(NREGS-1). R0 has no storage.
  // Unmasked registers get no shadow flops at all.
  for (genvar i = 1; i < NREGS; i++) begin : g_gr
    logic [WIDTH-1:0] gr_q;
    logic             wr_hit;

    assign wr_hit = LE && (WA == AW'(i));

    if (SHADOW_MASK[i]) begin : g_shadowed
      logic [WIDTH-1:0] shadow_q;

      // GR with shadow: a restore overrides a same-cycle write.
      // NOTE: this storage is reset explicitly. Clr must clear every GR, so the array
      // is built from flops, not from an unresettable RAM macro.
      always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)             gr_q <= '0;
        else if (RestShadow) gr_q <= shadow_q;
        else if (wr_hit)     gr_q <= WD;
      end

      // Shadow copy captures the pre-edge GR value, so a same-cycle write is not captured.
      always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)             shadow_q <= '0;
        else if (SaveShadow) shadow_q <= gr_q;
      end
    end else begin : g_plain
      // Plain GR: only the write port updates it.
      always_ff @(posedge Clk or posedge Clr) begin
        if (Clr)         gr_q <= '0;
        else if (wr_hit) gr_q <= WD;
      end
    end

    assign gr_view[i] = gr_q;
  end

  // Read ports are forced to zero while Clr is held. This also suppresses the bypass.
  assign QA = Clr ? '0 : read_port(RA_A, gr_view[RA_A], LE, WA, WD);
  assign QB = Clr ? '0 : read_port(RA_B, gr_view[RA_B], LE, WA, WD);

endmodule

// File: tb/tb_register_file_shadowed.sv
// Self-checking bench for register_file_shadowed.
// Two instances share one stimulus stream:
//   - the default 32 x 32 build with mask 0x0303_0302;
//   - a 16 x 64 build with mask 0x0102.
// Directed steps come first, then random traffic. An array-level reference
// model supplies the expected values.
module tb_register_file_shadowed;

  logic        Clk;
  logic        Clr;
  logic        le;
  logic        save;
  logic        rest;
  logic [4:0]  wa;
  logic [4:0]  ra_a;
  logic [4:0]  ra_b;
  logic [63:0] wd;

  logic [31:0] qa32, qb32;
  logic [63:0] qa16, qb16;
  logic        sv32, sv16;

  int errors = 0;
  int checks = 0;

  register_file_shadowed dut32 (
    .Clk(Clk), .Clr(Clr), .LE(le), .WA(wa), .WD(wd[31:0]),
    .RA_A(ra_a), .RA_B(ra_b), .QA(qa32), .QB(qb32),
    .SaveShadow(save), .RestShadow(rest), .ShadowValid(sv32)
  );

  register_file_shadowed #(
    .WIDTH(64), .NREGS(16), .SHADOW_MASK(16'h0102)
  ) dut16 (
    .Clk(Clk), .Clr(Clr), .LE(le), .WA(wa[3:0]), .WD(wd),
    .RA_A(ra_a[3:0]), .RA_B(ra_b[3:0]), .QA(qa16), .QB(qb16),
    .SaveShadow(save), .RestShadow(rest), .ShadowValid(sv16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model. Index 0 is the 32x32 build, index 1 is the 16x64 build.
  logic [63:0] m_gr [2][32];
  logic [63:0] m_sh [2][32];
  logic        m_sv [2];

  function automatic int  m_n(int k);      return (k == 0) ? 32 : 16; endfunction
  function automatic logic [31:0] m_mask(int k);
    return (k == 0) ? 32'h0303_0302 : 32'h0000_0102;
  endfunction
  function automatic logic [63:0] m_wmask(int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_gr[k][i] = '0;
        m_sh[k][i] = '0;
      end
      m_sv[k] = 1'b0;
    end
  endfunction

  // Value a read port must show right now for address a.
  function automatic logic [63:0] model_read(int k, logic [4:0] a);
    int n;
    int ai;
    n  = m_n(k);
    ai = int'(a) % n;
    if (Clr || ai == 0) return '0;
    if (le && (int'(wa) % n) == ai) return wd & m_wmask(k);
    return m_gr[k][ai];
  endfunction

  // Apply one clock edge using the current inputs and the pre-edge state.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] og [32];
      logic [63:0] os [32];
      int n;
      int wi;
      logic [31:0] msk;
      n   = m_n(k);
      msk = m_mask(k);
      wi  = int'(wa) % n;
      for (int i = 0; i < 32; i++) begin
        og[i] = m_gr[k][i];
        os[i] = m_sh[k][i];
      end
      for (int i = 1; i < n; i++) begin
        if (rest && msk[i])          m_gr[k][i] = os[i];
        else if (le && wi == i)      m_gr[k][i] = wd & m_wmask(k);
        if (save && msk[i])          m_sh[k][i] = og[i];
      end
      if (save)      m_sv[k] = 1'b1;
      else if (rest) m_sv[k] = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("qa32",  {32'b0, qa32}, model_read(0, ra_a));
    check("qb32",  {32'b0, qb32}, model_read(0, ra_b));
    check("sv32",  {63'b0, sv32}, {63'b0, m_sv[0]});
    check("qa16",  qa16,          model_read(1, ra_a));
    check("qb16",  qb16,          model_read(1, ra_b));
    check("sv16",  {63'b0, sv16}, {63'b0, m_sv[1]});
  endtask

  // Apply inputs, then compare everything at the following falling edge.
  task automatic drive(input logic le_i, input logic [4:0] wa_i, input logic [63:0] wd_i,
                       input logic [4:0] ra_a_i, input logic [4:0] ra_b_i,
                       input logic save_i, input logic rest_i);
    le = le_i; wa = wa_i; wd = wd_i; ra_a = ra_a_i; ra_b = ra_b_i;
    save = save_i; rest = rest_i;
    @(negedge Clk);
    compare_all();
  endtask

  // Advance through a rising edge and update the model to match.
  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  // Watchdog: the run must end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  r_wa, r_ra_a, r_ra_b;
    logic [63:0] r_wd;
    logic        r_le, r_save, r_rest;

    Clr = 1'b1; le = 1'b0; save = 1'b0; rest = 1'b0;
    wa = '0; ra_a = 5'd5; ra_b = 5'd1; wd = '0;
    model_clear();

    // Reset state while Clr is asserted.
    #1;
    check("rst_qa32", {32'b0, qa32}, 64'h0);
    check("rst_qa16", qa16, 64'h0);
    check("rst_sv32", {63'b0, sv32}, 64'h0);
    check("rst_sv16", {63'b0, sv16}, 64'h0);
    #12;
    Clr = 1'b0;
    @(posedge Clk); #1;

    // Test 1: load GR5 and take a snapshot, then pulse Clr mid-cycle.
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b0, 1'b0);
    check("t1_gr5_pre",  {32'b0, qa32}, 64'hDEAD_BEEF);
    check("t1_sv_pre",   {63'b0, sv32}, 64'h1);
    tick();
    #2;
    Clr = 1'b1; le = 1'b1; wa = 5'd5; wd = 64'h0BAD_F00D; ra_a = 5'd5; save = 1'b1;
    #1;
    check("t1_clr_qa32", {32'b0, qa32}, 64'h0);
    check("t1_clr_qa16", qa16, 64'h0);
    check("t1_clr_sv32", {63'b0, sv32}, 64'h0);
    check("t1_clr_sv16", {63'b0, sv16}, 64'h0);
    @(posedge Clk); #1;
    check("t1_hold_qa32", {32'b0, qa32}, 64'h0);
    check("t1_hold_sv32", {63'b0, sv32}, 64'h0);
    le = 1'b0; save = 1'b0; rest = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    model_clear();
    @(posedge Clk); #1;
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b0, 1'b0);
    check("t1_after_gr5", {32'b0, qa32}, 64'h0);
    tick();

    // Test 2: writes to R0 are discarded, and a write bypasses to the readers.
    drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b0);
    check("t2_r0_qa32", {32'b0, qa32}, 64'h0);
    check("t2_r0_qa16", qa16, 64'h0);
    tick();
    drive(1'b1, 5'd7, 64'h1234_5678, 5'd0, 5'd7, 1'b0, 1'b0);
    check("t2_byp_qb32", {32'b0, qb32}, 64'h1234_5678);
    check("t2_byp_qb16", qb16, 64'h1234_5678);
    tick();
    drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd7, 1'b0, 1'b0);
    check("t2_held_qa32", {32'b0, qa32}, 64'h1234_5678);
    check("t2_held_qa16", qa16, 64'h1234_5678);
    tick();

    // Test 3: save and restore touch the masked GR1 but not the unmasked GR2.
    drive(1'b1, 5'd1, 64'hA, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd2, 64'hB, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b0, 5'd0, 64'h0, 5'd1, 5'd2, 1'b1, 1'b0);
    check("t3_sv_before", {63'b0, sv32}, 64'h0);
    tick();
    drive(1'b1, 5'd1, 64'hC, 5'd1, 5'd2, 1'b0, 1'b0);
    check("t3_sv_saved", {63'b0, sv32}, 64'h1);
    tick();
    drive(1'b1, 5'd2, 64'hD, 5'd1, 5'd2, 1'b0, 1'b0); tick();
    drive(1'b0, 5'd0, 64'h0, 5'd1, 5'd2, 1'b0, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0, 5'd1, 5'd2, 1'b0, 1'b0);
    check("t3_gr1_32", {32'b0, qa32}, 64'hA);
    check("t3_gr2_32", {32'b0, qb32}, 64'hD);
    check("t3_gr1_16", qa16, 64'hA);
    check("t3_gr2_16", qb16, 64'hD);
    check("t3_sv_rest", {63'b0, sv32}, 64'h0);
    check("t3_sv16_rest", {63'b0, sv16}, 64'h0);
    tick();

    // Test 4: a restore beats a write to masked GR8 but not a write to unmasked GR3.
    drive(1'b1, 5'd8, 64'h88, 5'd8, 5'd3, 1'b0, 1'b0); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd8, 5'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd8, 64'h99, 5'd8, 5'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd8, 64'h55, 5'd8, 5'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd8, 5'd3, 1'b0, 1'b0);
    check("t4_gr8_32", {32'b0, qa32}, 64'h88);
    check("t4_gr8_16", qa16, 64'h88);
    tick();
    drive(1'b1, 5'd3, 64'h55, 5'd8, 5'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd8, 5'd3, 1'b0, 1'b0);
    check("t4_gr3_32", {32'b0, qb32}, 64'h55);
    check("t4_gr8_again", {32'b0, qa32}, 64'h88);
    tick();

    // Test 5: a save misses a same-cycle write, then save plus restore swaps the values.
    drive(1'b1, 5'd9, 64'h11, 5'd9, 5'd9, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd9, 64'h77, 5'd9, 5'd9, 1'b1, 1'b0); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b0, 1'b0);
    check("t5_gr9_written", {32'b0, qa32}, 64'h77);
    tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b1, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b0, 1'b0);
    check("t5_swap_gr9_32", {32'b0, qa32}, 64'h11);
    check("t5_swap_gr9_16", qa16, 64'h77);
    check("t5_swap_sv", {63'b0, sv32}, 64'h1);
    tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b0, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b0, 1'b0);
    check("t5_shadow9", {32'b0, qa32}, 64'h77);
    check("t5_sv_idle", {63'b0, sv32}, 64'h0);
    tick();
    // A restore with no valid snapshot still copies the stale shadow.
    drive(1'b1, 5'd9, 64'h66, 5'd9, 5'd9, 1'b0, 1'b1); tick();
    drive(1'b0, 5'd0, 64'h0,  5'd9, 5'd9, 1'b0, 1'b0);
    check("t5_stale_rest", {32'b0, qa32}, 64'h77);
    tick();

    // Random traffic against the model. About a quarter of the reads target the write address.
    for (int c = 0; c < 400; c++) begin
      r_le   = ($urandom_range(0, 3) != 0);
      r_wa   = 5'($urandom);
      r_wd   = {$urandom, $urandom};
      r_ra_a = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      r_ra_b = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom);
      r_save = ($urandom_range(0, 7) == 0);
      r_rest = ($urandom_range(0, 7) == 0);
      drive(r_le, r_wa, r_wd, r_ra_a, r_ra_b, r_save, r_rest);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
